acc_seq_monitor: RTL and testbench
==================================

// Module: acc_seq_monitor
// PURPOSE
//  Receive-side checker for the 4-phase accumulator sequencer (phases NEG_OP, AND, NEG_ACC, ADD).
//  Observes the accumulator output bus and a copy of the operand-load strobe.
//  Recovers the loaded operand from the stream, then predicts and checks every
//  following value, so corrupted or desynchronised sequences are flagged.
//  Sits beside the sequencer on the same clk; purely an observer with no back-pressure.
// PARAMETERS
//  WIDTH    32  data width of acc_in/operand; all arithmetic is modulo 2^WIDTH
//  CNT_W    8   width of err_count; the counter saturates at 2^CNT_W-1
//  STICKY   1   1: ERROR state holds until load/reset; 0: return to TRACK after a flagged cycle
// PORTS
//  clk            in   1      rising-edge clock, shared with the sequencer
//  reset          in   1      synchronous, active-high
//  load_in        in   1      operand-load strobe, sampled on clk
//  acc_in         in   WIDTH  sequencer output acc(t), the registered value
//  operand        out  WIDTH  recovered operand R1
//  operand_valid  out  1      high while in TRACK or ERROR
//  mismatch       out  1      single-cycle pulse when acc_in differs from the prediction
//  locked         out  1      high only in TRACK
//  err_count      out  CNT_W  count of mismatches, saturating
//  state          out  2      IDLE=0, SYNC=1, TRACK=2, ERROR=3
// BEHAVIOUR
//  Sequencer model, mirrored internally:
//   - ph: 2-bit phase counter. load_in forces ph<=0; otherwise ph<=ph+1 (wraps 3->0).
//   - acc(t+1) = f_ph(t)(R1, acc(t)), where f0=-R1, f1=R1&acc, f2=-acc, f3=R1+acc.
//   - Negation is two's-complement; the carry out of the add is discarded.
//  Internal registers: ph; prev_ph<=ph each cycle; prev_acc<=acc_in each cycle.
//   exp = f_prev_ph(operand, prev_acc).
//  Reset (synchronous):
//   - state=IDLE, ph=0, prev_ph=0, prev_acc=0, operand=0.
//   - All outputs are 0 in the next cycle.
//  FSM transitions, evaluated on clk:
//   - Any state, load_in=1: -> SYNC. operand_valid<=0; err_count keeps its value. Load wins over all other events.
//   - IDLE: waits for load_in. acc_in is ignored.
//   - SYNC, prev_ph==0: operand<=-acc_in, state->TRACK. No check on this cycle.
//   - TRACK: if acc_in!=exp, mismatch<=1 on the next cycle, err_count++ (saturating), state->ERROR.
//   - ERROR, STICKY=1: stays in ERROR, checks continue, mismatch still pulses, err_count still increments.
//   - ERROR, STICKY=0: returns to TRACK on the first cycle where acc_in==exp.
//  Latency: mismatch and err_count update exactly 1 cycle after the offending acc_in is sampled.
//  Boundaries:
//   - load_in held high for several cycles: stays in SYNC with ph pinned at 0. Recovery happens on the 2nd cycle after load_in falls.
//   - Reset asserted mid-sequence: operand, err_count and state are cleared, with no mismatch pulse.
//   - A load coincident with a mismatch cycle: the mismatch is suppressed and err_count is unchanged.
//   - Operand value 0 is legal: the expected stream is 0,0,0,0.
// CONFIGURATION
//  ACCMON_ERR_COUNT_EN
//   - Defined: err_count is implemented as specified above.
//   - Undefined: the counter logic is removed and err_count is tied to 0. mismatch and the FSM are unchanged.
// TESTING
//  T1 reset: reset=1 for 2 cycles -> state=0, operand=0, mismatch=0, err_count=0.
//  T2 lock: load with R1=5, stream FFFFFFFB,00000001,FFFFFFFF,00000004 repeating
//     -> operand=00000005, locked=1, no mismatch over 20 cycles.
//  T3 wrap: R1=80000000, stream 80000000,80000000,80000000,00000000 -> locked, err_count=0.
//  T4 fault: after T2 lock, force one ph1 sample to 00000003
//     -> mismatch pulses 1 cycle later, state=3, err_count=1.
//     With STICKY=0 the next correct sample returns state to 2.
//  T5 relock: load during ERROR, new R1=0x10 (stream FFFFFFF0,00000010,FFFFFFF0,00000000)
//     -> SYNC then TRACK, operand=00000010, err_count held.
//  T6 saturate (CNT_W=2, STICKY=1): 5 consecutive faulty samples
//     -> err_count stops at 3; macro undefined -> err_count stays 0.

Source files
------------

// File: rtl/acc_seq_monitor.sv
// Receive-side checker for the 4-phase accumulator sequencer: recovers the operand, then predicts and checks acc_in.
// Optional error counter is built only when ACCMON_ERR_COUNT_EN is defined; otherwise err_count is tied to 0.
module acc_seq_monitor #(
    parameter int WIDTH  = 32,
    parameter int CNT_W  = 8,
    parameter int STICKY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_in,
    input  logic [WIDTH-1:0] acc_in,
    output logic [WIDTH-1:0] operand,
    output logic             operand_valid,
    output logic             mismatch,
    output logic             locked,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       state
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SYNC  = 2'd1;
    localparam logic [1:0] TRACK = 2'd2;
    localparam logic [1:0] ERROR = 2'd3;

    logic [1:0]       ph, prevPh;
    logic [WIDTH-1:0] prevAcc, expVal;
    logic             checking, diff;

    always_comb begin
        expVal = '0;
        case (prevPh)
            2'd0:    expVal = -operand;
            2'd1:    expVal = operand & prevAcc;
            2'd2:    expVal = -prevAcc;
            default: expVal = operand + prevAcc;
        endcase
    end

    assign checking      = (state == TRACK || state == ERROR) && !load_in;
    assign diff          = acc_in != expVal;
    assign operand_valid = (state == TRACK || state == ERROR);
    assign locked        = (state == TRACK);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ph       <= 2'd0;
            prevPh   <= 2'd0;
            prevAcc  <= '0;
            operand  <= '0;
            mismatch <= 1'b0;
        end else begin
            ph       <= load_in ? 2'd0 : ph + 2'd1;
            prevPh   <= ph;
            prevAcc  <= acc_in;
            mismatch <= checking && diff;
            if (load_in) begin
                state <= SYNC;
            end else begin
                case (state)
                    // ph==1 marks the 2nd cycle after load falls, even when load was held
                    SYNC: if (prevPh == 2'd0 && ph == 2'd1) begin
                        operand <= -acc_in;
                        state   <= TRACK;
                    end
                    TRACK: if (diff) state <= ERROR;
                    ERROR: if (!diff && STICKY == 0) state <= TRACK;
                    default: ;
                endcase
            end
        end
    end

`ifdef ACCMON_ERR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            err_count <= '0;
        else if (checking && diff && err_count != {CNT_W{1'b1}})
            err_count <= err_count + 1'b1;
    end
`else
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_acc_seq_monitor.sv
// Bench for acc_seq_monitor: a golden sequencer drives three monitor configurations checked against a reference model.
module tb_acc_seq_monitor;
`ifdef ACCMON_ERR_COUNT_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, load_in;
    logic [31:0] acc_in;
    logic [31:0] opQ [3];
    logic        ovQ [3], misQ [3], lockQ [3];
    logic [1:0]  stQ [3];
    logic [7:0]  cntA, cntB;
    logic [1:0]  cntC;
    logic [31:0] cntW [3];
    assign cntW[0] = {24'b0, cntA};
    assign cntW[1] = {24'b0, cntB};
    assign cntW[2] = {30'b0, cntC};

    acc_seq_monitor #(.WIDTH(32), .CNT_W(8), .STICKY(1)) dutA (.clk(clk), .reset(reset), .load_in(load_in),
        .acc_in(acc_in), .operand(opQ[0]), .operand_valid(ovQ[0]), .mismatch(misQ[0]), .locked(lockQ[0]),
        .err_count(cntA), .state(stQ[0]));
    acc_seq_monitor #(.WIDTH(32), .CNT_W(8), .STICKY(0)) dutB (.clk(clk), .reset(reset), .load_in(load_in),
        .acc_in(acc_in), .operand(opQ[1]), .operand_valid(ovQ[1]), .mismatch(misQ[1]), .locked(lockQ[1]),
        .err_count(cntB), .state(stQ[1]));
    acc_seq_monitor #(.WIDTH(32), .CNT_W(2), .STICKY(1)) dutC (.clk(clk), .reset(reset), .load_in(load_in),
        .acc_in(acc_in), .operand(opQ[2]), .operand_valid(ovQ[2]), .mismatch(misQ[2]), .locked(lockQ[2]),
        .err_count(cntC), .state(stQ[2]));

    // Model: st uses the published state codes; age counts clean samples since the last load.
    typedef struct {
        int          st;
        int          age;
        logic [31:0] r1;
        logic [31:0] last;
        int          cnt;
        logic        mis;
    } mdl_t;

    mdl_t        m [3];
    bit          stk [3];
    int          cmax [3];
    int          tests = 0, fails = 0;
    string       phase = "init";
    int          seqPh = 0;
    logic [31:0] seqAcc = 32'h0, r1 = 32'h0;

    function automatic logic [31:0] fph(input int k, input logic [31:0] r, input logic [31:0] a);
        case (k)
            0:       return -r;
            1:       return r & a;
            2:       return -a;
            default: return r + a;
        endcase
    endfunction

    function automatic mdl_t step(input mdl_t p, input bit sticky, input int cm,
                                  input bit rst, input bit ld, input logic [31:0] a);
        mdl_t        n;
        logic [31:0] e;
        n     = p;
        n.mis = 1'b0;
        if (rst) begin
            n.st = 0; n.age = 0; n.r1 = '0; n.last = '0; n.cnt = 0;
            return n;
        end
        e      = fph((p.age - 1) % 4, p.r1, p.last);
        n.last = a;
        if (ld) begin
            n.st  = 1;
            n.age = 0;
            return n;
        end
        n.age = p.age + 1;
        if (p.st == 1 && p.age == 1) begin
            n.r1 = -a;
            n.st = 2;
        end else if (p.st >= 2) begin
            if (a != e) begin
                n.mis = 1'b1;
                n.st  = 3;
                if (p.cnt < cm) n.cnt = p.cnt + 1;
            end else if (!sticky) begin
                n.st = 2;
            end
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            fails++;
            $error("FAIL %s/%s got=%h want=%h", phase, tag, obs, want);
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("state%0d", i), {30'b0, stQ[i]}, m[i].st);
            chk($sformatf("operand%0d", i), opQ[i], m[i].r1);
            chk($sformatf("valid%0d", i), {31'b0, ovQ[i]}, {31'b0, (m[i].st >= 2)});
            chk($sformatf("locked%0d", i), {31'b0, lockQ[i]}, {31'b0, (m[i].st == 2)});
            chk($sformatf("mismatch%0d", i), {31'b0, misQ[i]}, {31'b0, m[i].mis});
            chk($sformatf("cnt%0d", i), cntW[i], m[i].cnt);
        end
    endtask

    // stX corrupts the sequencer's register (stream stays self-consistent); busX corrupts only the bus
    task automatic tick(input bit rst, input bit ld, input logic [31:0] stX, input logic [31:0] busX);
        logic [31:0] nxt;
        seqAcc  = seqAcc ^ stX;
        reset   = rst;
        load_in = ld;
        acc_in  = seqAcc ^ busX;
        @(posedge clk);
        for (int i = 0; i < 3; i++) m[i] = step(m[i], stk[i], cmax[i], rst, ld, acc_in);
        nxt    = fph(seqPh, r1, seqAcc);
        seqPh  = ld ? 0 : (seqPh + 1) % 4;
        seqAcc = nxt;
        #1;
        checkAll();
    endtask

    task automatic lockOn(input logic [31:0] v, input int holdCycles);
        r1 = v;
        for (int i = 0; i < holdCycles; i++) tick(1'b0, 1'b1, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic waitFor(input logic [31:0] v);
        for (int i = 0; i < 8 && seqAcc != v; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wait_bound", seqAcc, v);
    endtask

    initial begin
        logic [31:0] held;
        int          misSeen;
        stk[0] = 1'b1; stk[1] = 1'b0; stk[2] = 1'b1;
        cmax[0] = EN ? 255 : 0; cmax[1] = EN ? 255 : 0; cmax[2] = EN ? 3 : 0;
        for (int i = 0; i < 3; i++) m[i] = '{st: 0, age: 0, r1: '0, last: '0, cnt: 0, mis: 1'b0};
        reset = 1'b1; load_in = 1'b0; acc_in = 32'h0;

        phase = "T1";
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        chk("rst_state", {30'b0, stQ[0]}, 32'd0);
        chk("rst_operand", opQ[0], 32'h0);
        chk("rst_cnt", cntW[0], 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);

        phase = "T2";
        lockOn(32'h5, 1);
        misSeen = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 32'h0, 32'h0);
            misSeen += misQ[0] + misQ[1] + misQ[2];
        end
        chk("operand5", opQ[0], 32'h5);
        chk("locked", {31'b0, lockQ[1]}, 32'h1);
        chk("no_mis", misSeen, 32'h0);

        phase = "T3";
        r1 = 32'h8000_0000;
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("held_sync", {30'b0, stQ[0]}, 32'd1);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("held_track", {30'b0, stQ[0]}, 32'd2);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_operand", opQ[0], 32'h8000_0000);
        chk("wrap_cnt", cntW[0], 32'h0);

        phase = "T4";
        lockOn(32'h5, 1);
        waitFor(32'h1);
        tick(1'b0, 1'b0, 32'h2, 32'h0);
        chk("fault_mis", {31'b0, misQ[0]}, 32'h1);
        chk("fault_state", {30'b0, stQ[0]}, 32'd3);
        chk("fault_cnt", cntW[0], EN ? 32'h1 : 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sticky_hold", {30'b0, stQ[0]}, 32'd3);
        chk("nonsticky_back", {30'b0, stQ[1]}, 32'd2);
        chk("pulse_once", {31'b0, misQ[0]}, 32'h0);

        phase = "T5";
        held = cntW[0];
        r1 = 32'h10;
        tick(1'b0, 1'b1, 32'h0, 32'h40);
        chk("load_mis_supp", {31'b0, misQ[0]}, 32'h0);
        chk("relock_sync", {30'b0, stQ[0]}, 32'd1);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("relock_operand", opQ[0], 32'h10);
        chk("relock_track", {30'b0, stQ[0]}, 32'd2);
        chk("cnt_held", cntW[0], held);

        phase = "T6";
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 32'h100, 32'h0);
        chk("sat_cnt", cntW[2], EN ? 32'h3 : 32'h0);
        chk("sat_state", {30'b0, stQ[2]}, 32'd3);

        phase = "midreset";
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        chk("mr_state", {30'b0, stQ[0]}, 32'd0);
        chk("mr_cnt", cntW[0], 32'h0);
        chk("mr_mis", {31'b0, misQ[0]}, 32'h0);
        chk("mr_operand", opQ[0], 32'h0);

        phase = "zero";
        lockOn(32'h0, 2);
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 32'h0, 32'h0);
        chk("zero_locked", {31'b0, lockQ[0]}, 32'h1);
        chk("zero_acc", acc_in, 32'h0);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            bit          rst, ld;
            logic [31:0] sx, bx;
            rst = ($urandom_range(0, 299) == 0);
            ld  = ($urandom_range(0, 39) == 0);
            sx  = ($urandom_range(0, 29) == 0) ? $urandom : 32'h0;
            bx  = ($urandom_range(0, 49) == 0) ? $urandom : 32'h0;
            if (ld) r1 = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            tick(rst, ld, sx, bx);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
